traffic_gen: RTL and testbench
==============================

// Module: traffic_gen
// PURPOSE
//  Synthetic NoC flit source for the test harness. Emits NUM_PKTS packets of PKT_LEN flits on a
//  valid/ready stream, with LFSR-controlled injection gaps. Sits directly upstream of the harness
//  delay line (shift_reg) and router injection port; sole producer of stimulus flits.
// PARAMETERS
//  DATA_WIDTH  64      flit width; must be >= 64
//  DEST_WIDTH  4       destination id width
//  PKT_LEN     4       flits per packet, >= 1
//  NUM_PKTS    16      packets per run, >= 1
//  INJ_RATE    256     injection probability in 1/256 units, 0..256 (256 = always)
//  SEED        16'hACE1 LFSR reset value, must be non-zero
// PORTS
//  clk        in   1           clock
//  rst_n      in   1           reset, asynchronous, active-low
//  start      in   1           run trigger pulse; accepted only in IDLE or DONE
//  dest_i     in   DEST_WIDTH  destination for all packets of the run, sampled on accepted start
//  valid_o    out  1           flit valid
//  ready_i    in   1           downstream ready
//  data_o     out  DATA_WIDTH  flit payload
//  dest_o     out  DEST_WIDTH  flit destination
//  last_o     out  1           tail flit marker
//  done_o     out  1           all NUM_PKTS packets accepted
//  pkt_cnt_o  out  16          packets fully accepted this run
// BEHAVIOUR
//  - Reset: valid_o, last_o, done_o = 0; data_o, dest_o, pkt_cnt_o = 0; state IDLE; LFSR = SEED.
//  - FSM IDLE -> (start) GAP -> (hit) SEND -> (tail accepted) SEND | GAP | DONE; DONE -(start)-> GAP.
//  - LFSR: 16-bit Galois, mask 16'hB400; advances every cycle outside IDLE/DONE.
//    hit = ({1'b0, lfsr[7:0]} < INJ_RATE). INJ_RATE=0 never injects; 256 always.
//  - GAP: on hit, enter SEND next cycle; valid_o registered, asserted in SEND only.
//  - Handshake: transfer when valid_o && ready_i. While valid_o=1 and ready_i=0, data_o/dest_o/
//    last_o held stable; valid_o never deasserted before transfer.
//  - Payload: data_o[DW-1 -: 16] = packet id (0-based); data_o[DW-17 -: 8] = flit index;
//    remaining bits 0 (see CONFIGURATION). last_o = 1 on flit index PKT_LEN-1.
//  - Tail transfer: pkt_cnt_o increments same edge. If count reaches NUM_PKTS -> DONE; else if hit
//    that cycle -> stay SEND, next head flit presented next cycle (back-to-back); else -> GAP.
//  - DONE: done_o = 1, valid_o = 0, held until start. start in DONE clears pkt_cnt_o, flit index,
//    done_o, resamples dest_i; LFSR NOT reseeded (continues sequence).
//  - start while in GAP/SEND ignored. Async reset mid-packet aborts it; no partial-packet recovery.
//  - Widths: flit index wraps never (PKT_LEN <= 256); packet id is pkt_cnt_o[15:0].
// CONFIGURATION
//  TRAFFIC_GEN_TIMESTAMP_EN defined: free-running 32-bit cycle counter (reset 0, counts every clk);
//   data_o[31:0] of every flit of a packet = counter value when that packet's head first asserted
//   valid_o (latched, constant through the packet, including stalls).
//  Not defined: data_o[31:0] = 0; counter not instantiated.
// STRUCTURE
//  - Package traffic_gen_pkg: state enum (IDLE, GAP, SEND, DONE), LFSR_MASK = 16'hB400,
//    field offsets/widths for packet id, flit index, timestamp.
//  - Sub-module tg_lfsr: 16-bit Galois LFSR with seed param, advance enable, async reset.
// TESTING
//  1 INJ_RATE=256, ready_i=1, start @cycle 0 -> 64 flits on cycles 2..65 contiguous, last_o on every
//    4th, done_o=1 from cycle 66, pkt_cnt_o=16.
//  2 INJ_RATE=256, ready_i toggling 1010.. -> data/dest/last stable across stalls, 64 transfers,
//    ids 0..15 in order, flit idx 0..3 per packet.
//  3 INJ_RATE=0, start -> valid_o=0 for 1000 cycles, pkt_cnt_o=0, done_o=0.
//  4 INJ_RATE=64, ready_i=1 -> 16 packets, never split by gaps, mean gap ~3 cycles; restart from DONE
//    with new dest_i=5 -> dest_o=5, pkt_cnt_o restarts at 0.
//  5 rst_n low mid-packet (flit idx 2) -> all outputs 0 same time, IDLE; fresh start yields id 0 idx 0.
//  6 TRAFFIC_GEN_TIMESTAMP_EN, ready_i=0 for 10 cycles at head -> data_o[31:0] equals head-assert cycle
//    on all 4 flits; without macro -> data_o[31:0]=0.

Source files
------------

// File: rtl/traffic_gen_pkg.sv
// Shared types and field layout for the synthetic NoC flit source (traffic_gen).
package traffic_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GAP  = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } tg_state_e;

    localparam logic [15:0] LFSR_MASK = 16'hB400;

    // Payload layout: packet id in the top 16 bits, flit index in the next 8,
    // optional timestamp in the low 32 bits.
    localparam int PKT_ID_W   = 16;
    localparam int FLIT_IDX_W = 8;
    localparam int TS_W       = 32;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_MASK) : (s >> 1);
    endfunction

endpackage

// File: rtl/tg_lfsr.sv
// 16-bit Galois LFSR used to pace packet injection; advances only when enabled.
module tg_lfsr
    import traffic_gen_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en_i,
    output logic [15:0] state_o
);

    logic [15:0] lfsr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    lfsr_q <= SEED;
        else if (en_i) lfsr_q <= lfsr_next(lfsr_q);
    end

    assign state_o = lfsr_q;

endmodule

// File: rtl/traffic_gen.sv
// Synthetic flit source: NUM_PKTS packets of PKT_LEN flits with LFSR-paced gaps.
// Define TRAFFIC_GEN_TIMESTAMP_EN to stamp each packet's head-valid cycle into data_o[31:0].
module traffic_gen
    import traffic_gen_pkg::*;
#(
    parameter int          DATA_WIDTH = 64,
    parameter int          DEST_WIDTH = 4,
    parameter int          PKT_LEN    = 4,
    parameter int          NUM_PKTS   = 16,
    parameter int          INJ_RATE   = 256,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DEST_WIDTH-1:0] dest_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [DEST_WIDTH-1:0] dest_o,
    output logic                  last_o,
    output logic                  done_o,
    output logic [15:0]           pkt_cnt_o
);

    tg_state_e             state_q;
    logic                  valid_q, last_q, done_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DEST_WIDTH-1:0] dest_q;
    logic [15:0]           pkt_cnt_q, pkt_cnt_d;
    logic [FLIT_IDX_W-1:0] idx_q, idx_d;
    logic [15:0]           lfsr;
    logic [7:0]            unused_lfsr_hi;
    logic                  hit, tail_xfer, last_pkt, head_load;
    logic [TS_W-1:0]       ts_head, ts_body;

    tg_lfsr #(.SEED(SEED)) u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (state_q == GAP || state_q == SEND),
        .state_o (lfsr)
    );

    assign unused_lfsr_hi = lfsr[15:8];
    assign hit       = ({1'b0, lfsr[7:0]} < 9'(INJ_RATE));
    assign idx_d     = idx_q + 8'd1;
    assign pkt_cnt_d = pkt_cnt_q + 16'd1;
    assign tail_xfer = (state_q == SEND) && ready_i && last_q;
    assign last_pkt  = (pkt_cnt_q == 16'(NUM_PKTS - 1));
    assign head_load = ((state_q == GAP) && hit) || (tail_xfer && !last_pkt && hit);

`ifdef TRAFFIC_GEN_TIMESTAMP_EN
    logic [TS_W-1:0] cyc_q, ts_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q <= '0;
            ts_q  <= '0;
        end else begin
            cyc_q <= cyc_q + 32'd1;
            if (head_load) ts_q <= ts_head;
        end
    end

    // Counter value during the first cycle the head shows valid.
    assign ts_head = cyc_q + 32'd1;
    assign ts_body = ts_q;
`else
    assign ts_head = '0;
    assign ts_body = '0;
`endif

    function automatic logic [DATA_WIDTH-1:0] mk_flit(input logic [15:0] id,
                                                     input logic [FLIT_IDX_W-1:0] idx,
                                                     input logic [TS_W-1:0] ts);
        logic [DATA_WIDTH-1:0] d;
        d = '0;
        d[DATA_WIDTH-1 -: PKT_ID_W]            = id;
        d[DATA_WIDTH-1-PKT_ID_W -: FLIT_IDX_W] = idx;
        d[TS_W-1:0]                            = ts;
        return d;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            done_q    <= 1'b0;
            data_q    <= '0;
            dest_q    <= '0;
            pkt_cnt_q <= '0;
            idx_q     <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q   <= GAP;
                        done_q    <= 1'b0;
                        pkt_cnt_q <= '0;
                        idx_q     <= '0;
                        dest_q    <= dest_i;
                    end
                end
                GAP: begin
                    if (hit) begin
                        state_q <= SEND;
                        valid_q <= 1'b1;
                        idx_q   <= '0;
                        data_q  <= mk_flit(pkt_cnt_q, '0, ts_head);
                        last_q  <= (PKT_LEN == 1);
                    end
                end
                SEND: begin
                    // valid_q is always high here; outputs move only on a transfer.
                    if (ready_i) begin
                        if (!last_q) begin
                            idx_q  <= idx_d;
                            data_q <= mk_flit(pkt_cnt_q, idx_d, ts_body);
                            last_q <= (idx_d == 8'(PKT_LEN - 1));
                        end else begin
                            pkt_cnt_q <= pkt_cnt_d;
                            if (last_pkt) begin
                                state_q <= DONE;
                                valid_q <= 1'b0;
                                last_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end else if (hit) begin
                                idx_q  <= '0;
                                data_q <= mk_flit(pkt_cnt_d, '0, ts_head);
                                last_q <= (PKT_LEN == 1);
                            end else begin
                                state_q <= GAP;
                                valid_q <= 1'b0;
                                last_q  <= 1'b0;
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign valid_o   = valid_q;
    assign data_o    = data_q;
    assign dest_o    = dest_q;
    assign last_o    = last_q;
    assign done_o    = done_q;
    assign pkt_cnt_o = pkt_cnt_q;

endmodule

// File: tb/tb_traffic_gen.sv
// Scoreboard bench for traffic_gen: three instances (always / 25% / never injecting).
module tb_traffic_gen;

    localparam int DW = 64, DESTW = 4, PL = 4, NP = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic             start_v [3];
    logic [DESTW-1:0] dest_in [3];
    logic             ready   [3];
    logic             valid   [3];
    logic [DW-1:0]    data    [3];
    logic [DESTW-1:0] dest_out[3];
    logic             last    [3];
    logic             done    [3];
    logic [15:0]      pkt_cnt [3];

    traffic_gen #(.DATA_WIDTH(DW), .DEST_WIDTH(DESTW), .PKT_LEN(PL), .NUM_PKTS(NP), .INJ_RATE(256)) u_full (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .dest_i(dest_in[0]), .valid_o(valid[0]),
        .ready_i(ready[0]), .data_o(data[0]), .dest_o(dest_out[0]), .last_o(last[0]),
        .done_o(done[0]), .pkt_cnt_o(pkt_cnt[0]));
    traffic_gen #(.DATA_WIDTH(DW), .DEST_WIDTH(DESTW), .PKT_LEN(PL), .NUM_PKTS(NP), .INJ_RATE(64)) u_part (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .dest_i(dest_in[1]), .valid_o(valid[1]),
        .ready_i(ready[1]), .data_o(data[1]), .dest_o(dest_out[1]), .last_o(last[1]),
        .done_o(done[1]), .pkt_cnt_o(pkt_cnt[1]));
    traffic_gen #(.DATA_WIDTH(DW), .DEST_WIDTH(DESTW), .PKT_LEN(PL), .NUM_PKTS(NP), .INJ_RATE(0)) u_zero (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .dest_i(dest_in[2]), .valid_o(valid[2]),
        .ready_i(ready[2]), .data_o(data[2]), .dest_o(dest_out[2]), .last_o(last[2]),
        .done_o(done[2]), .pkt_cnt_o(pkt_cnt[2]));

    typedef struct {
        logic [15:0]      id;
        logic [7:0]       idx;
        logic [DESTW-1:0] dest;
        logic             last;
    } flit_t;

    flit_t q0[$];
    flit_t q1[$];
    int checks = 0;
    int errors = 0;
    int cyc;
    int rmode[2];

    // Bench cycle counter; mirrors the free-running timestamp reference.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_run(input int d, input logic [DESTW-1:0] dst);
        flit_t f;
        for (int p = 0; p < NP; p++)
            for (int i = 0; i < PL; i++) begin
                f.id = 16'(p); f.idx = 8'(i); f.dest = dst; f.last = (i == PL - 1);
                if (d == 0) q0.push_back(f);
                else        q1.push_back(f);
            end
    endtask

    function automatic int qsize(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    task automatic do_start(input int d, input logic [DESTW-1:0] dst, output int s);
        @(posedge clk); #1;
        dest_in[d] = dst;
        start_v[d] = 1'b1;
        s = cyc;
        if (d < 2) push_run(d, dst);
        @(posedge clk); #1;
        start_v[d] = 1'b0;
    endtask

    task automatic wait_done(input int d, input int budget, input string tag);
        int k;
        k = 0;
        while (!done[d] && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_done"}, done[d], 1'b1);
        chk({tag, "_pkt_cnt"}, pkt_cnt[d], 16'(NP));
        if (d < 2) chk({tag, "_sb_empty"}, qsize(d), 0);
    endtask

    // Ready drivers: 0 = always, 1 = toggle, 2 = random, 3 = held low.
    initial begin
        forever begin
            @(posedge clk); #1;
            for (int d = 0; d < 2; d++)
                case (rmode[d])
                    0:       ready[d] = 1'b1;
                    1:       ready[d] = ~ready[d];
                    2:       ready[d] = 1'($urandom_range(0, 1));
                    default: ready[d] = 1'b0;
                endcase
        end
    end

    // Monitor: pops the scoreboard on each transfer, checks stall stability and packet continuity.
    logic          pv[2], pr[2], plast[2], pbody[2];
    logic [DW-1:0] pd[2];
    logic [DESTW-1:0] pdst[2];
    logic [31:0]   ts_exp[2];

    initial begin
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                flit_t e;
                int qs;
                logic [DW-1:0] ed;
                logic [31:0] ts;
                if (!rst_n) begin
                    pv[d] = 1'b0;
                    pbody[d] = 1'b0;
                end else begin
                    qs = qsize(d);
                    if (pv[d] && !pr[d]) begin
                        chk("hold_valid", valid[d], 1'b1);
                        chk("hold_payload", {data[d], dest_out[d], last[d]}, {pd[d], pdst[d], plast[d]});
                    end else if (valid[d]) begin
                        chk("sb_has_entry", qs != 0, 1'b1);
                        if (qs != 0) begin
                            if (d == 0) e = q0[0];
                            else        e = q1[0];
                            if (e.idx == 8'd0) ts_exp[d] = 32'(cyc);
                        end
                    end
                    if (pbody[d]) chk("no_split", valid[d], 1'b1);
                    pbody[d] = 1'b0;
                    if (valid[d] && ready[d] && qs != 0) begin
                        if (d == 0) e = q0.pop_front();
                        else        e = q1.pop_front();
`ifdef TRAFFIC_GEN_TIMESTAMP_EN
                        ts = ts_exp[d];
`else
                        ts = 32'd0;
`endif
                        ed = {e.id, e.idx, 8'h00, ts};
                        chk("flit_data", data[d], ed);
                        chk("flit_dest", dest_out[d], e.dest);
                        chk("flit_last", last[d], e.last);
                        pbody[d] = !e.last;
                    end
                    pv[d] = valid[d]; pr[d] = ready[d]; pd[d] = data[d];
                    pdst[d] = dest_out[d]; plast[d] = last[d];
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, k, vcnt;
        logic [31:0] exp_ts;
        for (int d = 0; d < 3; d++) begin
            start_v[d] = 1'b0; dest_in[d] = '0; ready[d] = 1'b1;
        end
        rmode[0] = 0; rmode[1] = 0;
        for (int d = 0; d < 2; d++) begin
            pv[d] = 1'b0; pr[d] = 1'b0; pbody[d] = 1'b0; ts_exp[d] = '0;
        end

        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++)
            chk("reset_outputs", {valid[d], last[d], done[d], data[d], dest_out[d], pkt_cnt[d]}, '0);
        @(negedge clk);
        rst_n = 1'b1;

        // Full-rate run: exact flit window and done timing.
        do_start(0, 4'd3, s0);
        for (int r = 1; r <= 70; r++) begin
            @(negedge clk);
            chk("t1_timing", {valid[0], done[0]},
                {(cyc - s0 >= 2) && (cyc - s0 <= 65), (cyc - s0 >= 66)});
        end
        chk("t1_pkt_cnt", pkt_cnt[0], 16'(NP));
        chk("t1_sb_empty", qsize(0), 0);

        // Toggling ready, with a start pulse mid-run that must be ignored.
        rmode[0] = 1;
        do_start(0, 4'd9, s0);
        @(negedge clk);
        chk("t2_restart_cnt", {done[0], pkt_cnt[0]}, 17'd0);
        repeat (20) @(negedge clk);
        @(posedge clk); #1;
        dest_in[0] = 4'd2; start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        wait_done(0, 400, "t2");

        // Head stalled by ready low: timestamp field fixed at head-assert cycle.
        rmode[0] = 3; ready[0] = 1'b0;
        do_start(0, 4'd6, s0);
        repeat (11) @(negedge clk);
`ifdef TRAFFIC_GEN_TIMESTAMP_EN
        exp_ts = 32'(s0 + 2);
`else
        exp_ts = 32'd0;
`endif
        chk("t6_head_valid", valid[0], 1'b1);
        chk("t6_head_ts", data[0][31:0], exp_ts);
        chk("t6_head_idx", data[0][DW-1 -: 24], 24'd0);
        rmode[0] = 0;
        wait_done(0, 200, "t6");

        // Partial injection rate with random back-pressure, then restart with dest 5.
        rmode[1] = 2;
        do_start(1, 4'($urandom_range(0, 15)), s0);
        wait_done(1, 3000, "t4a");
        do_start(1, 4'd5, s0);
        @(negedge clk);
        chk("t4_restart_cnt", {done[1], pkt_cnt[1]}, 17'd0);
        chk("t4_restart_dest", dest_out[1], 4'd5);
        wait_done(1, 3000, "t4b");

        // Zero injection rate: nothing ever emitted.
        do_start(2, 4'd1, s0);
        vcnt = 0;
        for (int r = 0; r < 1000; r++) begin
            @(negedge clk);
            if (valid[2]) vcnt++;
        end
        chk("t3_valid_cycles", vcnt, 0);
        chk("t3_state", {done[2], pkt_cnt[2]}, 17'd0);

        // Async reset while flit index 2 is on the bus.
        rmode[0] = 0;
        do_start(0, 4'd7, s0);
        repeat (4) @(negedge clk);
        chk("t5_pre_idx", {valid[0], data[0][DW-1 -: 24]}, {1'b1, 16'd0, 8'd2});
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_reset_outputs", {valid[0], last[0], done[0], data[0], dest_out[0], pkt_cnt[0]}, '0);
        q0.delete();
        q1.delete();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        do_start(0, 4'd1, s0);
        k = 0;
        @(negedge clk);
        while (!valid[0] && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("t5_fresh_valid", valid[0], 1'b1);
        chk("t5_fresh_head", data[0][DW-1 -: 24], 24'd0);
        wait_done(0, 200, "t5");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
